// File: rtl/mib_pkg.sv
// Shared MIB definitions: bus widths, FSM states, local command payload and
// the error read pattern returned when MIB_SLAVE_ERR_RESP_EN is defined.
package mib_pkg;

  localparam int unsigned MIB_AD_BITS   = 16;
  localparam int unsigned CMD_ADDR_BITS = 24;
  localparam int unsigned CMD_DATA_BITS = 32;
  localparam int unsigned MSN_MSB       = 23;
  localparam int unsigned MSN_LSB       = 20;

  localparam logic [CMD_DATA_BITS-1:0] ERR_RDATA = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR2,
    ST_WDATA_HI,
    ST_WDATA_LO,
    ST_CMD_WAIT,
    ST_WR_ACK,
    ST_RD_HI,
    ST_RD_LO
  } mib_state_t;

  typedef struct packed {
    logic                     rd_wr_n;
    logic [CMD_ADDR_BITS-1:0] byte_addr;
    logic [CMD_DATA_BITS-1:0] wdata;
  } cmd_req_t;

  // Slave-select nibble of a full MIB address.
  function automatic logic [3:0] msn_of(input logic [CMD_ADDR_BITS-1:0] addr);
    return addr[MSN_MSB:MSN_LSB];
  endfunction

endpackage

// File: rtl/mib_slave_cmd_bridge_if.sv
// MIB slave pins plus local cmd-bus pins of the bridge. Names are from the
// bridge's point of view; the master modport is the environment side.
interface mib_slave_cmd_bridge_if;
  import mib_pkg::*;

  logic                     i_mib_start;
  logic                     i_mib_rd_wr_n;
  logic [MIB_AD_BITS-1:0]   i_mib_ad;
  logic [MIB_AD_BITS-1:0]   o_mib_ad;
  logic                     o_mib_ad_oe;
  logic                     o_mib_slave_ack;
  logic                     o_cmd_sel;
  logic                     o_cmd_rd_wr_n;
  logic [CMD_ADDR_BITS-1:0] o_cmd_byte_addr;
  logic [CMD_DATA_BITS-1:0] o_cmd_wdata;
  logic                     i_cmd_ack;
  logic [CMD_DATA_BITS-1:0] i_cmd_rdata;
  logic                     o_cmd_timeout;

  modport slave (
    input  i_mib_start, i_mib_rd_wr_n, i_mib_ad, i_cmd_ack, i_cmd_rdata,
    output o_mib_ad, o_mib_ad_oe, o_mib_slave_ack, o_cmd_sel, o_cmd_rd_wr_n,
           o_cmd_byte_addr, o_cmd_wdata, o_cmd_timeout
  );

  modport master (
    output i_mib_start, i_mib_rd_wr_n, i_mib_ad, i_cmd_ack, i_cmd_rdata,
    input  o_mib_ad, o_mib_ad_oe, o_mib_slave_ack, o_cmd_sel, o_cmd_rd_wr_n,
           o_cmd_byte_addr, o_cmd_wdata, o_cmd_timeout
  );

endinterface

// File: rtl/cmd_ack_timer.sv
// Loadable down-counter; o_expire_c flags the last clock of the running window.
module cmd_ack_timer #(
  parameter int unsigned P_CNT_BITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_srst,
  input  logic                  i_load,
  input  logic [P_CNT_BITS-1:0] i_load_val,
  input  logic                  i_run,
  output logic                  o_expire_c
);

  logic [P_CNT_BITS-1:0] r_cnt;

  // Load has priority; otherwise count down while running and stop at zero.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - P_CNT_BITS'(1);
    end
  end

  assign o_expire_c = i_run && (r_cnt == '0);

endmodule

// File: rtl/mib_slave_cmd_bridge.sv
// MIB slave endpoint: decodes A1/A2/W1/W2 phases, checks the slave-select
// nibble, replays the access as one local cmd strobe and returns ack/read
// data on the AD bus. Optional macro MIB_SLAVE_ERR_RESP_EN turns a local
// timeout into an MIB response (0xDEADBEEF for reads, ack for writes).
module mib_slave_cmd_bridge
  import mib_pkg::*;
#(
  parameter logic [3:0]  P_MIB_MSN              = 4'h0,
  parameter int unsigned P_CMD_ACK_TIMEOUT_CLKS = 16
) (
  input logic                   i_sysclk,
  input logic                   i_srst,
  mib_slave_cmd_bridge_if.slave io_mib
);

  localparam int unsigned ADDR_HI_BITS = CMD_ADDR_BITS - MIB_AD_BITS;
  localparam int unsigned TMR_BITS     = $clog2(P_CMD_ACK_TIMEOUT_CLKS);
  localparam logic [TMR_BITS-1:0] TMR_LOAD = TMR_BITS'(P_CMD_ACK_TIMEOUT_CLKS - 1);

`ifdef MIB_SLAVE_ERR_RESP_EN
  localparam bit ERR_RESP_EN = 1'b1;
`else
  localparam bit ERR_RESP_EN = 1'b0;
`endif

  mib_state_t               r_state;
  logic [ADDR_HI_BITS-1:0]  r_addr_hi;
  logic                     r_rd_wr_n;
  logic [MIB_AD_BITS-1:0]   r_wdata_hi;
  logic [MIB_AD_BITS-1:0]   r_rdata_lo;
  cmd_req_t                 r_req;
  logic                     r_cmd_sel;
  logic [MIB_AD_BITS-1:0]   r_ad;
  logic                     r_oe;
  logic                     r_ack;
  logic                     r_timeout;

  logic [CMD_ADDR_BITS-1:0] w_addr;
  logic                     w_msn_match;
  logic                     w_resync;
  logic                     w_enter_wait;
  logic                     w_wait;
  logic                     w_expire;

  // Full address as seen during A2, and the decode helpers derived from it.
  assign w_addr       = {r_addr_hi, io_mib.i_mib_ad};
  assign w_msn_match  = (msn_of(w_addr) == P_MIB_MSN);
  assign w_resync     = io_mib.i_mib_start &&
                        (r_state inside {ST_IDLE, ST_ADDR2, ST_WDATA_HI, ST_WDATA_LO});
  assign w_enter_wait = !io_mib.i_mib_start &&
                        (((r_state == ST_ADDR2) && w_msn_match && r_rd_wr_n) ||
                         (r_state == ST_WDATA_LO));
  assign w_wait       = (r_state == ST_CMD_WAIT);

  // Ack window starts with the cmd strobe and lasts P_CMD_ACK_TIMEOUT_CLKS clocks.
  cmd_ack_timer #(
    .P_CNT_BITS (TMR_BITS)
  ) u_timer (
    .i_clk      (i_sysclk),
    .i_srst     (i_srst),
    .i_load     (w_enter_wait),
    .i_load_val (TMR_LOAD),
    .i_run      (w_wait),
    .o_expire_c (w_expire)
  );

  // Bridge FSM with registered MIB and cmd-bus outputs.
  always_ff @(posedge i_sysclk) begin
    if (i_srst) begin
      r_state    <= ST_IDLE;
      r_addr_hi  <= '0;
      r_rd_wr_n  <= 1'b0;
      r_wdata_hi <= '0;
      r_rdata_lo <= '0;
      r_req      <= '0;
      r_cmd_sel  <= 1'b0;
      r_ad       <= '0;
      r_oe       <= 1'b0;
      r_ack      <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_cmd_sel <= 1'b0;
      r_timeout <= 1'b0;
      if (w_resync) begin
        r_addr_hi <= io_mib.i_mib_ad[ADDR_HI_BITS-1:0];
        r_rd_wr_n <= io_mib.i_mib_rd_wr_n;
        r_state   <= ST_ADDR2;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_IDLE;
          ST_ADDR2: begin
            if (!w_msn_match) begin
              r_state <= ST_IDLE;
            end else begin
              r_req.rd_wr_n   <= r_rd_wr_n;
              r_req.byte_addr <= {4'h0, w_addr[MSN_LSB-1:0]};
              if (r_rd_wr_n) begin
                r_cmd_sel <= 1'b1;
                r_state   <= ST_CMD_WAIT;
              end else begin
                r_state   <= ST_WDATA_HI;
              end
            end
          end
          ST_WDATA_HI: begin
            r_wdata_hi <= io_mib.i_mib_ad;
            r_state    <= ST_WDATA_LO;
          end
          ST_WDATA_LO: begin
            r_req.wdata <= {r_wdata_hi, io_mib.i_mib_ad};
            r_cmd_sel   <= 1'b1;
            r_state     <= ST_CMD_WAIT;
          end
          ST_CMD_WAIT: begin
            if (io_mib.i_cmd_ack) begin
              r_ack <= 1'b1;
              if (r_req.rd_wr_n) begin
                r_ad       <= io_mib.i_cmd_rdata[CMD_DATA_BITS-1:MIB_AD_BITS];
                r_rdata_lo <= io_mib.i_cmd_rdata[MIB_AD_BITS-1:0];
                r_oe       <= 1'b1;
                r_state    <= ST_RD_HI;
              end else begin
                r_state    <= ST_WR_ACK;
              end
            end else if (w_expire) begin
              r_timeout <= 1'b1;
              if (ERR_RESP_EN) begin
                r_ack <= 1'b1;
                if (r_req.rd_wr_n) begin
                  r_ad       <= ERR_RDATA[CMD_DATA_BITS-1:MIB_AD_BITS];
                  r_rdata_lo <= ERR_RDATA[MIB_AD_BITS-1:0];
                  r_oe       <= 1'b1;
                  r_state    <= ST_RD_HI;
                end else begin
                  r_state    <= ST_WR_ACK;
                end
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
          ST_WR_ACK: begin
            r_ack   <= 1'b0;
            r_state <= ST_IDLE;
          end
          ST_RD_HI: begin
            r_ad    <= r_rdata_lo;
            r_state <= ST_RD_LO;
          end
          ST_RD_LO: begin
            r_ad    <= '0;
            r_oe    <= 1'b0;
            r_ack   <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign io_mib.o_mib_ad        = r_ad;
  assign io_mib.o_mib_ad_oe     = r_oe;
  assign io_mib.o_mib_slave_ack = r_ack;
  assign io_mib.o_cmd_sel       = r_cmd_sel;
  assign io_mib.o_cmd_rd_wr_n   = r_req.rd_wr_n;
  assign io_mib.o_cmd_byte_addr = r_req.byte_addr;
  assign io_mib.o_cmd_wdata     = r_req.wdata;
  assign io_mib.o_cmd_timeout   = r_timeout;

endmodule

// File: tb/tb_mib_slave_cmd_bridge.sv
// Bench for mib_slave_cmd_bridge: transaction tasks lay out per-cycle stimulus
// and the expected output timeline from the MIB/cmd protocol rules; a negedge
// process compares every cycle and also pins a few hand-computed literals.
module tb_mib_slave_cmd_bridge;

  localparam int N  = 200;
  localparam int TO = 16;
  localparam logic [3:0] MSN = 4'h0;
`ifdef MIB_SLAVE_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  mib_slave_cmd_bridge_if bus ();

  mib_slave_cmd_bridge #(
    .P_MIB_MSN              (MSN),
    .P_CMD_ACK_TIMEOUT_CLKS (TO)
  ) dut (
    .i_sysclk (clk),
    .i_srst   (srst),
    .io_mib   (bus)
  );

  // per-cycle stimulus
  bit          s_srst [N];
  bit          s_start[N];
  bit          s_rw   [N];
  bit          s_cack [N];
  logic [15:0] s_ad   [N];
  logic [31:0] s_crd  [N];
  // per-cycle expectations
  bit          e_sel  [N];
  bit          e_rw   [N];
  bit          e_wchk [N];
  bit          e_ack  [N];
  bit          e_oe   [N];
  bit          e_to   [N];
  logic [23:0] e_addr [N];
  logic [31:0] e_wd   [N];
  logic [15:0] e_ad   [N];

  int cyc;
  bit running;
  int n_chk;
  int n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
  endtask

  task automatic drive_addr(input int c, input logic [23:0] addr, input bit rd);
    s_start[c]  = 1'b1;
    s_rw[c]     = rd;
    s_ad[c]     = {8'h00, addr[23:16]};
    s_ad[c+1]   = addr[15:0];
  endtask

  task automatic rd_rsp(input int r, input logic [31:0] d);
    e_oe[r]   = 1'b1; e_ack[r]   = 1'b1; e_ad[r]   = d[31:16];
    e_oe[r+1] = 1'b1; e_ack[r+1] = 1'b1; e_ad[r+1] = d[15:0];
  endtask

  // d = local ack delay after the strobe (negative: never acked)
  task automatic mib_read(input int c, input logic [23:0] addr, input int d, input logic [31:0] rd);
    int s;
    drive_addr(c, addr, 1'b1);
    if (addr[23:20] != MSN) return;
    s = c + 2;
    e_sel[s] = 1'b1; e_rw[s] = 1'b1; e_addr[s] = {4'h0, addr[19:0]};
    if (d >= 0) begin s_cack[s+d] = 1'b1; s_crd[s+d] = rd; end
    if (d >= 0 && d < TO) rd_rsp(s + d + 1, rd);
    else begin
      e_to[s+TO] = 1'b1;
      if (ERR_EN) rd_rsp(s + TO, 32'hDEADBEEF);
    end
  endtask

  task automatic mib_write(input int c, input logic [23:0] addr, input logic [31:0] wd, input int d);
    int s;
    drive_addr(c, addr, 1'b0);
    s_ad[c+2] = wd[31:16];
    s_ad[c+3] = wd[15:0];
    if (addr[23:20] != MSN) return;
    s = c + 4;
    e_sel[s] = 1'b1; e_rw[s] = 1'b0; e_wchk[s] = 1'b1;
    e_addr[s] = {4'h0, addr[19:0]}; e_wd[s] = wd;
    if (d >= 0) begin s_cack[s+d] = 1'b1; s_crd[s+d] = 32'h0BAD_0BAD; end
    if (d >= 0 && d < TO) e_ack[s+d+1] = 1'b1;
    else begin
      e_to[s+TO] = 1'b1;
      if (ERR_EN) e_ack[s+TO] = 1'b1;
    end
  endtask

  // Model comparison every cycle, plus literal anchors at hand-computed cycles.
  always @(negedge clk) begin
    if (running && cyc >= 1) begin
      check("cmd_sel",   32'(bus.o_cmd_sel),       32'(e_sel[cyc]));
      check("slave_ack", 32'(bus.o_mib_slave_ack), 32'(e_ack[cyc]));
      check("ad_oe",     32'(bus.o_mib_ad_oe),     32'(e_oe[cyc]));
      check("timeout",   32'(bus.o_cmd_timeout),   32'(e_to[cyc]));
      if (e_oe[cyc]) check("mib_ad", 32'(bus.o_mib_ad), 32'(e_ad[cyc]));
      if (e_sel[cyc]) begin
        check("cmd_rd_wr_n", 32'(bus.o_cmd_rd_wr_n),   32'(e_rw[cyc]));
        check("cmd_addr",    32'(bus.o_cmd_byte_addr), 32'(e_addr[cyc]));
      end
      if (e_wchk[cyc]) check("cmd_wdata", bus.o_cmd_wdata, e_wd[cyc]);
      case (cyc)
        1: begin
          check("rst_ad",    32'(bus.o_mib_ad),        32'h0);
          check("rst_addr",  32'(bus.o_cmd_byte_addr), 32'h0);
          check("rst_wdata", bus.o_cmd_wdata,          32'h0);
          check("rst_rw",    32'(bus.o_cmd_rd_wr_n),   32'h0);
        end
        9: begin
          check("lit_w_sel",   32'(bus.o_cmd_sel),       32'h1);
          check("lit_w_addr",  32'(bus.o_cmd_byte_addr), 32'h000004);
          check("lit_w_wdata", bus.o_cmd_wdata,          32'h01010202);
        end
        12:  check("lit_w_ack_early", 32'(bus.o_mib_slave_ack), 32'h0);
        13:  check("lit_w_ack",       32'(bus.o_mib_slave_ack), 32'h1);
        20: begin
          check("lit_rd_hi",    32'(bus.o_mib_ad),    32'h0101);
          check("lit_rd_hi_oe", 32'(bus.o_mib_ad_oe), 32'h1);
        end
        21:  check("lit_rd_lo",     32'(bus.o_mib_ad),        32'h0202);
        22:  check("lit_rd_oe_off", 32'(bus.o_mib_ad_oe),     32'h0);
        53:  check("lit_timeout",   32'(bus.o_cmd_timeout),   32'h1);
        131: check("lit_rst_oe",    32'(bus.o_mib_ad_oe),     32'h0);
        138: check("lit_post_rst",  32'(bus.o_mib_slave_ack), 32'h1);
        default: ;
      endcase
    end
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      s_srst[k] = 1'b0; s_start[k] = 1'b0; s_rw[k] = 1'b0; s_cack[k] = 1'b0;
      s_ad[k] = 16'h0; s_crd[k] = 32'h0;
      e_sel[k] = 1'b0; e_rw[k] = 1'b0; e_wchk[k] = 1'b0; e_ack[k] = 1'b0;
      e_oe[k] = 1'b0; e_to[k] = 1'b0; e_addr[k] = 24'h0; e_wd[k] = 32'h0; e_ad[k] = 16'h0;
    end
    n_chk = 0; n_pass = 0; running = 1'b0; cyc = 0;

    s_srst[0] = 1'b1; s_srst[1] = 1'b1; s_srst[2] = 1'b1;
    mib_write(5,  24'h000004, 32'h01010202, 3);
    mib_read (15, 24'h000004, 2, 32'h01010202);
    mib_read (24, 24'h100000, 2, 32'h11111111);          // other slave
    mib_write(27, 24'h100004, 32'h22223333, 1);           // other slave
    s_cack[32] = 1'b1; s_crd[32] = 32'hFFFFFFFF;           // spurious local ack
    mib_read (35, 24'h000008, -1, 32'h0);                 // local timeout
    mib_read (58, 24'h000040, TO - 1, 32'hA5A55A5A);      // ack on terminal count
    mib_read (80, 24'h000044, TO, 32'h99998888);          // ack one clock too late
    mib_write(103, 24'h000048, 32'h44445555, -1);         // write timeout
    mib_read (126, 24'h00000C, 1, 32'h55AA33CC);          // reset during RD_HI
    s_srst[130] = 1'b1; e_oe[131] = 1'b0; e_ack[131] = 1'b0;
    mib_write(133, 24'h000000, 32'h12345678, 0);
    mib_write(140, 24'h000010, 32'hCAFEF00D, 1);          // back-to-back pair
    mib_read (148, 24'h000010, 0, 32'h13579BDF);
    drive_addr(155, 24'h000020, 1'b0);                    // restart in WDATA_HI
    mib_read (157, 24'h000024, 2, 32'h0F0F1E1E);
    drive_addr(165, 24'h000030, 1'b0);                    // restart in WDATA_LO
    s_ad[167] = 16'h7777;
    mib_write(168, 24'h000028, 32'h00FF00FF, 0);
    mib_read (176, 24'h00002C, 4, 32'h2468ACE0);
    s_start[180] = 1'b1; s_rw[180] = 1'b0; s_ad[180] = 16'h0000; // start in CMD_WAIT

    running = 1'b1;
    for (int k = 0; k < N; k++) begin
      cyc               = k;
      srst              = s_srst[k];
      bus.i_mib_start   = s_start[k];
      bus.i_mib_rd_wr_n = s_rw[k];
      bus.i_mib_ad      = s_ad[k];
      bus.i_cmd_ack     = s_cack[k];
      bus.i_cmd_rdata   = s_crd[k];
      @(posedge clk);
      #1;
    end
    running = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mib_slave_cmd_bridge.md
Name: mib_slave_cmd_bridge

Overview:
- MIB slave endpoint inside each FPGA top (e.g. cs10_top), directly downstream of the board-level MIB master.
- Decodes the MIB address phases, write-data phases and read-data phases, and checks the 4-bit slave-select nibble.
- Replays each matching transaction as a single local cmd-bus access, then returns the ack/read data on the shared 16-bit AD bus.

Parameters:
- P_MIB_MSN, 4'h0, slave-select nibble compared against address bits [23:20].
- P_CMD_ACK_TIMEOUT_CLKS, 16, clocks to wait for local i_cmd_ack before abandoning the access; must be 2 or more.

Ports:
- i_sysclk  in  1  sole clock; MIB and cmd bus are both synchronous to it.
- i_srst  in  1  synchronous, active-high reset.
- i_mib_start  in  1  master pulse, one clock, during address phase 1.
- i_mib_rd_wr_n  in  1  1 = read, 0 = write; valid with i_mib_start.
- i_mib_ad  in  16  AD bus input, already IO-registered at top.
- o_mib_ad  out  16  AD bus drive value.
- o_mib_ad_oe  out  1  1 = top level drives AD pad, 0 = tri-state.
- o_mib_slave_ack  out  1  write ack / read-data-valid.
- o_cmd_sel  out  1  one-clock local command strobe.
- o_cmd_rd_wr_n  out  1  local direction.
- o_cmd_byte_addr  out  24  local address = {4'h0, addr[19:0]}.
- o_cmd_wdata  out  32  local write data.
- i_cmd_ack  in  1  local completion; one clock.
- i_cmd_rdata  in  32  local read data; valid with i_cmd_ack.
- o_cmd_timeout  out  1  one-clock pulse when a local access times out.

Behaviour:
- Reset: all outputs 0, o_mib_ad = 16'h0, state IDLE, timeout counter 0. Reset mid-transaction drops the access, releases AD (oe = 0) the next clock, and issues no ack.
- MIB phase order:
  - A1: i_mib_start = 1, AD[7:0] = addr[23:16], AD[15:8] ignored.
  - A2: AD = addr[15:0].
  - Writes then carry W1 = wdata[31:16] and W2 = wdata[15:0] on consecutive clocks.
- FSM states: IDLE, ADDR2, WDATA_HI, WDATA_LO, CMD_WAIT, WR_ACK, RD_HI, RD_LO.
- IDLE: on i_mib_start, latch addr_hi and rd_wr_n, go to ADDR2.
- ADDR2: latch addr_lo.
  - If addr[23:20] != P_MIB_MSN, go to IDLE. Nothing is driven and no cmd is issued.
  - Write: go to WDATA_HI.
  - Read: assert o_cmd_sel for this clock's successor (registered), go to CMD_WAIT.
- WDATA_HI: latch wdata[31:16].
- WDATA_LO: latch wdata[15:0], assert o_cmd_sel on the next clock, go to CMD_WAIT.
- CMD_WAIT:
  - Count clocks since o_cmd_sel.
  - On i_cmd_ack: a write goes to WR_ACK; a read captures i_cmd_rdata and goes to RD_HI.
  - Counter reaching P_CMD_ACK_TIMEOUT_CLKS: pulse o_cmd_timeout, go to IDLE, no MIB ack (the master times out on its own).
  - i_cmd_ack on the same clock as terminal count: ack wins.
- WR_ACK: o_mib_slave_ack = 1 for exactly one clock, then IDLE.
- RD_HI: o_mib_ad_oe = 1, o_mib_ad = rdata[31:16], ack = 1.
- RD_LO: o_mib_ad = rdata[15:0], ack = 1. Next clock: oe = 0, ack = 0, IDLE.
- o_mib_ad, o_mib_ad_oe and o_mib_slave_ack are registered (no combinational path from inputs).
- Latency: the write ack arrives 1 clock after i_cmd_ack. The read high word is on AD 1 clock after i_cmd_ack.
- i_mib_start outside IDLE:
  - In ADDR2, WDATA_HI, WDATA_LO: abort and treat it as a new A1 (resync).
  - In CMD_WAIT, WR_ACK, RD_HI, RD_LO: ignored.
- o_cmd_sel is never asserted while a previous access is outstanding.
- Spurious i_cmd_ack outside CMD_WAIT is ignored.

Optional Feature:
- Macro MIB_SLAVE_ERR_RESP_EN.
- Defined: a read timeout returns 32'hDEADBEEF via the normal RD_HI/RD_LO sequence with ack. A write timeout issues the WR_ACK pulse. o_cmd_timeout still pulses in both cases.
- Undefined: timeouts produce no MIB response, as specified above.

Decomposition:
- Shared package mib_pkg: state enum, MIB_AD_BITS = 16, CMD_ADDR_BITS = 24, CMD_DATA_BITS = 32, MSN bit range [23:20], error pattern 32'hDEADBEEF.
- One natural sub-module: cmd_ack_timer (loadable down-counter with expiry pulse), reusable by the mib_master side.

Test Plan:
- Write 0x000004 = 0x01010202 with local ack after 3 clocks -> o_cmd_byte_addr = 0x000004, o_cmd_wdata = 0x01010202, one sel pulse, ack 1 clock after i_cmd_ack.
- Read 0x000004 with i_cmd_rdata = 0x01010202 -> AD = 0x0101 then 0x0202 with ack high both clocks; oe high exactly 2 clocks.
- Address 0x100000 with P_MIB_MSN = 0 -> no o_cmd_sel, oe never asserted, no ack.
- Read 0x000008 with no local ack -> o_cmd_timeout after 16 clocks, no MIB ack. With MIB_SLAVE_ERR_RESP_EN: AD = 0xDEAD, 0xBEEF.
- i_srst asserted in RD_HI -> oe and ack low the next clock, IDLE; a following write to 0x000000 completes normally.
- Back-to-back write then read, start issued 1 clock after the previous ack falls -> both complete with correct data; i_mib_start in WDATA_HI restarts decode.
